// File: rtl/bitop_arbiter16_pkg.sv
// Shared constants for the two-requester bitwise-logic arbiter.
// Opcode and FSM encodings live here so the unit, arbiter and bench agree.
package bitop_arbiter16_pkg;
  localparam int WIDTH = 16;
  localparam int OP_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;
endpackage

// File: rtl/bitop_arbiter16_if.sv
// One requester's request and response valid/ready channels.
// master = requester side, slave = arbiter side.
interface bitop_arbiter16_if;
  import bitop_arbiter16_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OP_W-1:0]  req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_c;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_c
  );
endinterface

// File: rtl/bitop_unit16.sv
// Combinational 16-bit AND/OR/XOR/NOR unit; output forced to zero when E=0.
// Zero latency, no flow control; OverflowFlag is always 0 (no carry path).
module bitop_unit16
  import bitop_arbiter16_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  input  logic             E,
  output logic [WIDTH-1:0] C,
  output logic             OverflowFlag
);

  always_comb begin
    C = '0;
    if (E) begin
      case (op)
        OP_AND:  C = A & B;
        OP_OR:   C = A | B;
        OP_XOR:  C = A ^ B;
        default: C = ~(A | B);
      endcase
    end
  end

  assign OverflowFlag = 1'b0;

endmodule

// File: rtl/bitop_arbiter16.sv
// Round-robin arbiter sharing one bitop_unit16 between two requesters; IDLE->EXEC->RESP.
// Response valid two cycles after request handshake; a stalled response blocks new requests.
module bitop_arbiter16
  import bitop_arbiter16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  bitop_arbiter16_if.slave  ch0,
  bitop_arbiter16_if.slave  ch1,
  output logic              busy,
  output logic              last_grant
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             grant;
  logic             req0_rdy, req1_rdy;
  logic             rsp0_vld, rsp1_vld;
  logic             unit_en;
  logic [WIDTH-1:0] unit_c;
  logic             unused_ovf;

  // Lone requester wins outright; contention is settled by prio.
  assign grant = (ch0.req_valid && ch1.req_valid) ? prio_q : ch1.req_valid;

  bitop_unit16 u_unit (
    .A            (a_q),
    .B            (b_q),
    .op           (op_q),
    .E            (unit_en),
    .C            (unit_c),
    .OverflowFlag (unused_ovf)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    req0_rdy     = 1'b0;
    req1_rdy     = 1'b0;
    rsp0_vld     = 1'b0;
    rsp1_vld     = 1'b0;
    unit_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ch0.req_valid || ch1.req_valid) begin
          req0_rdy     = ~grant;
          req1_rdy     = grant;
          id_d         = grant;
          last_grant_d = grant;
          prio_d       = ~grant;
          a_d          = grant ? ch1.req_a  : ch0.req_a;
          b_d          = grant ? ch1.req_b  : ch0.req_b;
          op_d         = grant ? ch1.req_op : ch0.req_op;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unit_en = 1'b1;
        res_d   = unit_c;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp0_vld = ~id_q;
        rsp1_vld = id_q;
        if (id_q ? ch1.rsp_ready : ch0.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
    end
  end

  assign ch0.req_ready = req0_rdy;
  assign ch1.req_ready = req1_rdy;
  assign ch0.rsp_valid = rsp0_vld;
  assign ch1.rsp_valid = rsp1_vld;
  assign ch0.rsp_c     = rsp0_vld ? res_q : '0;
  assign ch1.rsp_c     = rsp1_vld ? res_q : '0;
  assign busy          = (state_q != ST_IDLE);
  assign last_grant    = last_grant_q;

endmodule

// File: tb/tb_bitop_arbiter16.sv
// Scoreboard bench for bitop_arbiter16: expected results queued at each request handshake,
// compared when the matching response channel completes.
module tb_bitop_arbiter16;
  import bitop_arbiter16_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, last_grant;

  bitop_arbiter16_if r0();
  bitop_arbiter16_if r1();

  bitop_arbiter16 dut (
    .clk        (clk),
    .reset      (reset),
    .ch0        (r0),
    .ch1        (r1),
    .busy       (busy),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Monitor: scoreboard push/pop, latency, last_grant and channel invariants.
  logic lg_pend = 1'b0;
  logic lg_id   = 1'b0;
  int   hs_cyc  = 0;
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      lg_pend = 1'b0;
      prev_v0 = 1'b0;
      prev_v1 = 1'b0;
    end else begin
      if (lg_pend) check("last_grant", 32'(last_grant), 32'(lg_id));
      lg_pend = 1'b0;
      check("ready_excl", 32'(r0.req_ready & r1.req_ready), 32'd0);
      check("ready_busy", 32'((r0.req_ready | r1.req_ready) & busy), 32'd0);
      if (!r0.rsp_valid) check("rsp0_c_zero", 32'(r0.rsp_c), 32'd0);
      if (!r1.rsp_valid) check("rsp1_c_zero", 32'(r1.rsp_c), 32'd0);
      check("rsp_excl", 32'(r0.rsp_valid & r1.rsp_valid), 32'd0);
      if (r0.req_valid && r0.req_ready) begin
        exp0.push_back(model(r0.req_a, r0.req_b, r0.req_op));
        lg_pend = 1'b1; lg_id = 1'b0; hs_cyc = cyc;
      end
      if (r1.req_valid && r1.req_ready) begin
        exp1.push_back(model(r1.req_a, r1.req_b, r1.req_op));
        lg_pend = 1'b1; lg_id = 1'b1; hs_cyc = cyc;
      end
      if (r0.rsp_valid && !prev_v0) check("latency0", 32'(cyc), 32'(hs_cyc + 2));
      if (r1.rsp_valid && !prev_v1) check("latency1", 32'(cyc), 32'(hs_cyc + 2));
      if (r0.rsp_valid && r0.rsp_ready) begin
        if (exp0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
        else check("rsp0_c", 32'(r0.rsp_c), 32'(exp0.pop_front()));
      end
      if (r1.rsp_valid && r1.rsp_ready) begin
        if (exp1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
        else check("rsp1_c", 32'(r1.rsp_c), 32'(exp1.pop_front()));
      end
      prev_v0 = r0.rsp_valid;
      prev_v1 = r1.rsp_valid;
    end
  end

  // Present a request from posedge+1 and hold it until accepted (bounded).
  task automatic drive_req(input int ch, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (ch == 0) begin r0.req_valid = 1'b1; r0.req_a = a; r0.req_b = b; r0.req_op = op; end
    else         begin r1.req_valid = 1'b1; r1.req_a = a; r1.req_b = b; r1.req_op = op; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((ch == 0) ? r0.req_ready : r1.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (ch == 0) r0.req_valid = 1'b0;
    else         r1.req_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  logic [1:0]  op_tab [4];
  logic [15:0] res_tab[4];

  initial begin
    op_tab  = '{2'b00, 2'b01, 2'b10, 2'b11};
    res_tab = '{16'h00AA, 16'hAAFF, 16'hAA55, 16'h5500};
    r0.req_valid = 1'b0; r0.req_a = '0; r0.req_b = '0; r0.req_op = '0; r0.rsp_ready = 1'b1;
    r1.req_valid = 1'b0; r1.req_a = '0; r1.req_b = '0; r1.req_op = '0; r1.rsp_ready = 1'b1;

    // Reset, then idle outputs.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd0);
    check("rst_rsp0_valid", 32'(r0.rsp_valid), 32'd0);
    check("rst_rsp1_valid", 32'(r1.rsp_valid), 32'd0);
    check("rst_rsp0_c", 32'(r0.rsp_c), 32'd0);
    check("rst_req_ready", 32'(r0.req_ready | r1.req_ready), 32'd0);

    // Single XOR on requester 0.
    drive_req(0, 16'hF0F0, 16'h0FF0, 2'b10);
    @(negedge clk);
    check("single_busy_exec", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_rsp0_valid", 32'(r0.rsp_valid), 32'd1);
    check("single_rsp0_c", 32'(r0.rsp_c), 32'h0000FF00);
    check("single_rsp1_valid", 32'(r1.rsp_valid), 32'd0);
    drain();

    // All opcodes on requester 1.
    for (int k = 0; k < 4; k++) begin
      drive_req(1, 16'hAAAA, 16'h00FF, op_tab[k]);
      @(negedge clk);
      @(negedge clk);
      check("opcode_rsp1_c", 32'(r1.rsp_c), 32'(res_tab[k]));
      check("opcode_rsp0_valid", 32'(r0.rsp_valid), 32'd0);
    end
    drain();

    // Backpressure on rsp0 while requester 1 waits.
    r0.rsp_ready = 1'b0;
    drive_req(0, 16'h00FF, 16'hFF0F, 2'b01);
    r1.req_valid = 1'b1; r1.req_a = 16'h1357; r1.req_b = 16'h0F0F; r1.req_op = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp0_valid", 32'(r0.rsp_valid), 32'd1);
      check("bp_rsp0_c", 32'(r0.rsp_c), 32'h0000FFFF);
      check("bp_req1_ready", 32'(r1.req_ready), 32'd0);
    end
    @(posedge clk); #1 r0.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_req1_accept", 32'(r1.req_ready), 32'd1);
    @(posedge clk); #1 r1.req_valid = 1'b0;
    drain();

    // Payload altered after acceptance; requester 1 withdraws before being granted.
    r0.rsp_ready = 1'b0;
    drive_req(0, 16'h3C3C, 16'hFFFF, 2'b00);
    r0.req_a = 16'h0000;
    r1.req_valid = 1'b1; r1.req_a = 16'hFFFF; r1.req_b = 16'h0001; r1.req_op = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("captured_rsp0_c", 32'(r0.rsp_c), 32'h00003C3C);
    check("withdraw_req1_ready", 32'(r1.req_ready), 32'd0);
    @(posedge clk); #1;
    r1.req_valid = 1'b0;
    r0.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("withdraw_rsp1_valid", 32'(r1.rsp_valid), 32'd0);
    end
    drain();

    // Reset while a response is pending: it must vanish.
    r0.rsp_ready = 1'b0;
    drive_req(0, 16'h1111, 16'h2222, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("prerst_rsp0_valid", 32'(r0.rsp_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    exp0.delete();
    @(negedge clk);
    check("midrst_rsp0_valid", 32'(r0.rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp0_c", 32'(r0.rsp_c), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    r0.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_rsp0_valid", 32'(r0.rsp_valid), 32'd0);
    end

    // Contention from reset: grants alternate 0,1,0.
    @(posedge clk); #1;
    reset = 1'b1;
    r0.req_valid = 1'b1; r0.req_a = 16'h1234; r0.req_b = 16'h00FF; r0.req_op = 2'b00;
    r1.req_valid = 1'b1; r1.req_a = 16'h1200; r1.req_b = 16'h0034; r1.req_op = 2'b10;
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (r0.req_ready || r1.req_ready) begin
          seen = 1'b1;
          break;
        end
      end
      check("contend_grant_seen", 32'(seen), 32'd1);
      check("contend_grant_id", 32'(r1.req_ready), 32'(k % 2));
      @(negedge clk);
      check("contend_last_grant", 32'(last_grant), 32'(k % 2));
    end
    @(posedge clk); #1;
    r0.req_valid = 1'b0;
    r1.req_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
